argmax_bin_sequencer: RTL and testbench

//  Sequences the argmax peak-search datapath across num_bins frequency bins of the CAF surface.
//  Per bin: programs the frequency-shift select, gates exactly buffer_length beats into argmax,

---
 rtl/argmax_bin_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_argmax_bin_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_bin_sequencer.sv
// Steps the argmax peak search across the frequency bins of the CAF surface.
// Each bin gets a fixed beat count into argmax, and the strongest result over all bins is kept.
module argmax_bin_sequencer #(
    parameter int buffer_length  = 10,
    parameter int num_bins       = 8,
    parameter int bin_bits       = 3,
    parameter int index_bits     = 4,
    parameter int out_max_bits   = 4,
    parameter int settle_cycles  = 2,
    parameter int timeout_cycles = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [bin_bits-1:0]     freq_sel,
    input  logic                    src_tvalid,
    output logic                    src_tready,
    output logic                    am_tvalid,
    input  logic                    am_tready,
    output logic                    am_rready,
    input  logic                    am_rvalid,
    input  logic [out_max_bits-1:0] am_max,
    input  logic [index_bits-1:0]   am_index,
    output logic [out_max_bits-1:0] best_max,
    output logic [index_bits-1:0]   best_index,
    output logic [bin_bits-1:0]     best_bin
);

    localparam int beat_w   = $clog2(buffer_length + 1);
    localparam int settle_w = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam int timer_w  = $clog2(timeout_cycles + 1);

    localparam logic [beat_w-1:0]   beat_last   = beat_w'(buffer_length - 1);
    localparam logic [beat_w-1:0]   beat_one    = beat_w'(1'b1);
    // A zero settle time still spends one cycle in SETTLE.
    localparam logic [settle_w-1:0] settle_last = settle_w'((settle_cycles > 0) ? settle_cycles - 1 : 0);
    localparam logic [settle_w-1:0] settle_one  = settle_w'(1'b1);
    localparam logic [timer_w-1:0]  timer_last  = timer_w'(timeout_cycles - 1);
    localparam logic [timer_w-1:0]  timer_one   = timer_w'(1'b1);
    localparam logic [bin_bits-1:0] bin_last    = bin_bits'(num_bins - 1);
    localparam logic [bin_bits-1:0] bin_one     = bin_bits'(1'b1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [beat_w-1:0]       beat_cnt_r;
    logic [settle_w-1:0]     settle_cnt_r;
    logic [timer_w-1:0]      timer_r;
    logic [bin_bits-1:0]     bin_r;
    logic [out_max_bits-1:0] cap_max_r;
    logic [index_bits-1:0]   cap_index_r;
    logic [out_max_bits-1:0] best_max_r;
    logic [index_bits-1:0]   best_index_r;
    logic [bin_bits-1:0]     best_bin_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    error_r;
    logic                    in_stream_s;
    logic                    beat_s;
    logic                    last_beat_s;
    logic                    timeout_s;

    // The handshake passes straight through while streaming, so the gate closes on the last beat's edge.
    assign in_stream_s = (state_r == ST_STREAM);
    assign beat_s      = in_stream_s & src_tvalid & am_tready;
    assign last_beat_s = beat_s & (beat_cnt_r == beat_last);
    assign timeout_s   = (state_r == ST_WAIT) & ~am_rvalid & (timer_r == timer_last);

    assign src_tready  = am_tready & in_stream_s;
    assign am_tvalid   = src_tvalid & in_stream_s;
    assign am_rready   = in_stream_s | (state_r == ST_WAIT);

    assign busy        = busy_r;
    assign done        = done_r;
    assign error       = error_r;
    assign freq_sel    = bin_r;
    assign best_max    = best_max_r;
    assign best_index  = best_index_r;
    assign best_bin    = best_bin_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_SETTLE;
                else       state_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == settle_last) state_s = ST_STREAM;
                else                             state_s = ST_SETTLE;
            end
            ST_STREAM: begin
                if (last_beat_s) state_s = ST_WAIT;
                else             state_s = ST_STREAM;
            end
            ST_WAIT: begin
                if (am_rvalid)      state_s = ST_UPDATE;
                else if (timeout_s) state_s = ST_IDLE;
                else                state_s = ST_WAIT;
            end
            ST_UPDATE: begin
                if (bin_r == bin_last) state_s = ST_DONE;
                else                   state_s = ST_SETTLE;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Counters, result capture, peak tracking and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r   <= {beat_w{1'b0}};
            settle_cnt_r <= {settle_w{1'b0}};
            timer_r      <= {timer_w{1'b0}};
            bin_r        <= {bin_bits{1'b0}};
            cap_max_r    <= {out_max_bits{1'b0}};
            cap_index_r  <= {index_bits{1'b0}};
            best_max_r   <= {out_max_bits{1'b0}};
            best_index_r <= {index_bits{1'b0}};
            best_bin_r   <= {bin_bits{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r        <= {bin_bits{1'b0}};
                        settle_cnt_r <= {settle_w{1'b0}};
                        beat_cnt_r   <= {beat_w{1'b0}};
                        busy_r       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_r != settle_last) begin
                        settle_cnt_r <= settle_cnt_r + settle_one;
                    end
                end
                ST_STREAM: begin
                    if (last_beat_s) begin
                        beat_cnt_r <= {beat_w{1'b0}};
                        timer_r    <= {timer_w{1'b0}};
                    end else if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r + beat_one;
                    end
                end
                ST_WAIT: begin
                    if (am_rvalid) begin
                        cap_max_r   <= am_max;
                        cap_index_r <= am_index;
                    end else if (timeout_s) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        timer_r <= timer_r + timer_one;
                    end
                end
                ST_UPDATE: begin
                    // Strictly greater wins, so a tie stays with the earlier bin.
                    if ((bin_r == {bin_bits{1'b0}}) || (cap_max_r > best_max_r)) begin
                        best_max_r   <= cap_max_r;
                        best_index_r <= cap_index_r;
                        best_bin_r   <= bin_r;
                    end
                    if (bin_r == bin_last) begin
                        done_r <= 1'b1;
                    end else begin
                        bin_r        <= bin_r + bin_one;
                        settle_cnt_r <= {settle_w{1'b0}};
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_bin_sequencer.sv
// Directed bench for argmax_bin_sequencer: a 4-bin search with hand-picked argmax results,
// plus stalls, timeout, mid-search reset, start filtering and settle timing.
module tb_argmax_bin_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, done, error;
    logic [2:0] freq_sel;
    logic       src_tvalid, src_tready, am_tvalid, am_tready, am_rready, am_rvalid;
    logic [3:0] am_max, am_index, best_max, best_index;
    logic [2:0] best_bin;

    logic       start6, src_tvalid6, am_tready6, am_rvalid6;
    logic [3:0] am_max6, am_index6;
    logic       busy_0, done_0, error_0, src_tready_0, am_tvalid_0, am_rready_0;
    logic [2:0] freq_sel_0, best_bin_0;
    logic [3:0] best_max_0, best_index_0;
    logic       busy_3, done_3, error_3, src_tready_3, am_tvalid_3, am_rready_3;
    logic [2:0] freq_sel_3, best_bin_3;
    logic [3:0] best_max_3, best_index_3;

    int checks = 0;
    int errors = 0;
    int total_beats = 0;

    argmax_bin_sequencer #(.num_bins(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .freq_sel(freq_sel), .src_tvalid(src_tvalid), .src_tready(src_tready),
        .am_tvalid(am_tvalid), .am_tready(am_tready), .am_rready(am_rready),
        .am_rvalid(am_rvalid), .am_max(am_max), .am_index(am_index),
        .best_max(best_max), .best_index(best_index), .best_bin(best_bin)
    );

    argmax_bin_sequencer #(.num_bins(4), .settle_cycles(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start6), .busy(busy_0), .done(done_0), .error(error_0),
        .freq_sel(freq_sel_0), .src_tvalid(src_tvalid6), .src_tready(src_tready_0),
        .am_tvalid(am_tvalid_0), .am_tready(am_tready6), .am_rready(am_rready_0),
        .am_rvalid(am_rvalid6), .am_max(am_max6), .am_index(am_index6),
        .best_max(best_max_0), .best_index(best_index_0), .best_bin(best_bin_0)
    );

    argmax_bin_sequencer #(.num_bins(4), .settle_cycles(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start6), .busy(busy_3), .done(done_3), .error(error_3),
        .freq_sel(freq_sel_3), .src_tvalid(src_tvalid6), .src_tready(src_tready_3),
        .am_tvalid(am_tvalid_3), .am_tready(am_tready6), .am_rready(am_rready_3),
        .am_rvalid(am_rvalid6), .am_max(am_max6), .am_index(am_index6),
        .best_max(best_max_3), .best_index(best_index_3), .best_bin(best_bin_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || freq_sel !== 3'd0) begin
            errors++;
            $display("FAIL start_accept: busy=%0b freq_sel=%0d expected busy=1 freq_sel=0", busy, freq_sel);
        end
    endtask

    // Streams nbeats into argmax for one bin, optionally answering with (mx, ix).
    task automatic do_bin(input int bin, input logic [3:0] mx, input logic [3:0] ix,
                          input bit stall, input bit spurious, input int nbeats, input bit respond);
        int  beats = 0;
        int  iter  = 0;
        bit  seen  = 1'b0;
        while (beats < nbeats && iter < 400) begin
            @(negedge clk);
            iter++;
            src_tvalid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            am_tready  = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            am_rvalid  = spurious && (iter <= 2);
            am_max     = 4'd15;
            am_index   = 4'd15;
            #1;
            checks++;
            if ((src_tready && !am_tready) || (am_tvalid && !src_tvalid)) begin
                errors++;
                $display("FAIL stream_gating: src_tready=%0b am_tvalid=%0b with am_tready=%0b src_tvalid=%0b",
                         src_tready, am_tvalid, am_tready, src_tvalid);
            end
            if (am_tvalid && am_tready) begin
                beats++;
                total_beats++;
                if (!seen) begin
                    seen = 1'b1;
                    checks++;
                    if (freq_sel !== bin[2:0]) begin
                        errors++;
                        $display("FAIL freq_sel_bin: got %0d expected %0d", freq_sel, bin);
                    end
                end
            end
        end
        am_rvalid = 1'b0;
        checks++;
        if (beats != nbeats) begin
            errors++;
            $display("FAIL beat_budget: bin %0d got %0d beats expected %0d", bin, beats, nbeats);
        end
        if (respond) begin
            src_tvalid = 1'b1;
            am_tready  = 1'b1;
            repeat (3) begin
                @(negedge clk);
                #1;
                checks++;
                if (am_tvalid || src_tready || !am_rready) begin
                    errors++;
                    $display("FAIL wait_gating: am_tvalid=%0b src_tready=%0b am_rready=%0b expected 0 0 1",
                             am_tvalid, src_tready, am_rready);
                end
                if (am_tvalid && am_tready) total_beats++;
            end
            @(negedge clk);
            am_rvalid = 1'b1;
            am_max    = mx;
            am_index  = ix;
            @(negedge clk);
            am_rvalid = 1'b0;
            am_max    = 4'd0;
            am_index  = 4'd0;
        end
    endtask

    // Called in the UPDATE cycle of the last bin.
    task automatic wait_done(input logic [3:0] emax, input logic [3:0] eidx, input logic [2:0] ebin,
                             input bit restart);
        int first = -1;
        int npulse = 0;
        logic busy_c1 = 1'b0, busy_c2 = 1'b0, busy_c3 = 1'b0, err_seen = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (done) begin
                npulse++;
                if (first < 0) first = c;
            end
            if (error) err_seen = 1'b1;
            if (c == 1) busy_c1 = busy;
            if (c == 2) busy_c2 = busy;
            if (c == 3) busy_c3 = busy;
        end
        checks++;
        if (first != 1 || npulse != 1 || err_seen) begin
            errors++;
            $display("FAIL done_pulse: first=%0d count=%0d error=%0b expected first=1 count=1 error=0",
                     first, npulse, err_seen);
        end
        checks++;
        if (busy_c1 !== 1'b1 || busy_c2 !== 1'b0 || busy_c3 !== restart) begin
            errors++;
            $display("FAIL busy_after_done: got %0b%0b%0b expected 10%0b", busy_c1, busy_c2, busy_c3, restart);
        end
        checks++;
        if (best_max !== emax || best_index !== eidx || best_bin !== ebin) begin
            errors++;
            $display("FAIL best_result: got max=%0d idx=%0d bin=%0d expected max=%0d idx=%0d bin=%0d",
                     best_max, best_index, best_bin, emax, eidx, ebin);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || freq_sel !== 3'd0 ||
            src_tready !== 1'b0 || am_tvalid !== 1'b0 || am_rready !== 1'b0 ||
            best_max !== 4'd0 || best_index !== 4'd0 || best_bin !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b done=%0b error=%0b fsel=%0d srdy=%0b amv=%0b amr=%0b best=%0d/%0d/%0d expected all 0",
                     busy, done, error, freq_sel, src_tready, am_tvalid, am_rready, best_max, best_index, best_bin);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        pulse_start();
        do_bin(0, 4'd5, 4'd3, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd9, 4'd7, 1'b0, 1'b0, 10, 1'b1);
        do_bin(2, 4'd2, 4'd1, 1'b0, 1'b0, 10, 1'b1);
        do_bin(3, 4'd9, 4'd0, 1'b0, 1'b0, 10, 1'b1);
        wait_done(4'd9, 4'd7, 3'd1, 1'b0);
    endtask

    task automatic test_stalls();
        total_beats = 0;
        pulse_start();
        do_bin(0, 4'd1, 4'd2, 1'b1, 1'b0, 10, 1'b1);
        do_bin(1, 4'd3, 4'd4, 1'b1, 1'b0, 10, 1'b1);
        do_bin(2, 4'd3, 4'd5, 1'b1, 1'b0, 10, 1'b1);
        do_bin(3, 4'd2, 4'd6, 1'b1, 1'b0, 10, 1'b1);
        wait_done(4'd3, 4'd4, 3'd1, 1'b0);
        checks++;
        if (total_beats != 40) begin
            errors++;
            $display("FAIL total_beats: got %0d expected 40", total_beats);
        end
    endtask

    task automatic test_timeout();
        int  err_c = -1;
        bit  bad = 1'b0;
        pulse_start();
        do_bin(0, 4'd4, 4'd9, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd7, 4'd2, 1'b0, 1'b0, 10, 1'b1);
        do_bin(2, 4'd0, 4'd0, 1'b0, 1'b0, 10, 1'b0);
        @(posedge clk);
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || am_tvalid) bad = 1'b1;
            if (error) begin
                err_c = c;
                break;
            end
        end
        checks++;
        if (err_c != 64 || bad) begin
            errors++;
            $display("FAIL timeout_latency: error after %0d cycles (spurious=%0b) expected 64", err_c, bad);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_busy: got %0b expected 0", busy);
        end
        @(negedge clk);
        checks++;
        if (error !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: error=%0b done=%0b busy=%0b expected 0 0 0", error, done, busy);
        end
        checks++;
        if (best_max !== 4'd7 || best_index !== 4'd2 || best_bin !== 3'd1) begin
            errors++;
            $display("FAIL timeout_hold: got %0d/%0d/%0d expected 7/2/1", best_max, best_index, best_bin);
        end
    endtask

    task automatic test_reset_mid();
        bit bad = 1'b0;
        pulse_start();
        do_bin(0, 4'd3, 4'd3, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd0, 4'd0, 1'b0, 1'b0, 3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || freq_sel !== 3'd0 || am_tvalid !== 1'b0 || src_tready !== 1'b0 ||
            am_rready !== 1'b0 || best_max !== 4'd0 || best_index !== 4'd0 || best_bin !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: busy=%0b fsel=%0d amv=%0b srdy=%0b amr=%0b best=%0d/%0d/%0d expected all 0",
                     busy, freq_sel, am_tvalid, src_tready, am_rready, best_max, best_index, best_bin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (busy || done || error) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_quiet: saw busy/done/error after reset, expected none");
        end
        pulse_start();
        do_bin(0, 4'd6, 4'd1, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd2, 4'd2, 1'b0, 1'b0, 10, 1'b1);
        do_bin(2, 4'd8, 4'd3, 1'b0, 1'b0, 10, 1'b1);
        do_bin(3, 4'd8, 4'd4, 1'b0, 1'b0, 10, 1'b1);
        wait_done(4'd8, 4'd3, 3'd2, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1;
        do_bin(0, 4'd3, 4'd3, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd4, 4'd4, 1'b0, 1'b1, 10, 1'b1);
        do_bin(2, 4'd1, 4'd5, 1'b0, 1'b1, 10, 1'b1);
        do_bin(3, 4'd4, 4'd6, 1'b0, 1'b1, 10, 1'b1);
        wait_done(4'd4, 4'd4, 3'd1, 1'b1);
        start = 1'b0;
        do_bin(0, 4'd1, 4'd1, 1'b0, 1'b0, 10, 1'b1);
        do_bin(1, 4'd0, 4'd2, 1'b0, 1'b0, 10, 1'b1);
        do_bin(2, 4'd1, 4'd3, 1'b0, 1'b0, 10, 1'b1);
        do_bin(3, 4'd0, 4'd4, 1'b0, 1'b0, 10, 1'b1);
        wait_done(4'd1, 4'd1, 3'd0, 1'b0);
    endtask

    task automatic test_settle();
        int f0 = -1, t0 = -1, f3 = -1, t3 = -1;
        @(negedge clk);
        start6 = 1'b1;
        @(negedge clk);
        start6 = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (f0 < 0 && freq_sel_0 == 3'd1) f0 = c;
            else if (f0 >= 0 && t0 < 0 && am_tvalid_0) t0 = c;
            if (f3 < 0 && freq_sel_3 == 3'd1) f3 = c;
            else if (f3 >= 0 && t3 < 0 && am_tvalid_3) t3 = c;
        end
        checks++;
        if (f0 < 0 || t0 - f0 != 1) begin
            errors++;
            $display("FAIL settle_zero: am_tvalid %0d cycles after freq_sel change expected 1", t0 - f0);
        end
        checks++;
        if (f3 < 0 || t3 - f3 != 3) begin
            errors++;
            $display("FAIL settle_three: am_tvalid %0d cycles after freq_sel change expected 3", t3 - f3);
        end
    endtask

    initial begin
        start       = 1'b0;
        src_tvalid  = 1'b1;
        am_tready   = 1'b1;
        am_rvalid   = 1'b0;
        am_max      = 4'd0;
        am_index    = 4'd0;
        start6      = 1'b0;
        src_tvalid6 = 1'b1;
        am_tready6  = 1'b1;
        am_rvalid6  = 1'b1;
        am_max6     = 4'd1;
        am_index6   = 4'd1;
        test_reset();
        test_basic();
        test_stalls();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
